skid_pipeline: RTL and testbench

// - Elastic pipeline of STAGES registered slices with valid/ready flow control.
// - Sits upstream of the enable-gated data registers.
// - Its out_valid && out_ready drives their en; out_data drives their in.
// - Every output and every ready is registered, so backpressure never forms a

---
 rtl/skid_pipeline_pkg.sv | 11 +
 rtl/skid_slice.sv | 90 +++++++++
 rtl/skid_pipeline.sv | 61 ++++++
 tb/tb_skid_pipeline.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/skid_pipeline_pkg.sv
// Shared definitions for the elastic skid-buffer pipeline.
// Holds the per-slice state encoding and the occupancy width helper.
package skid_pipeline_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;

    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/skid_slice.sv
// One registered pipeline slice: a 2-entry skid buffer with a registered ready.
// Output data is always the main register; the skid register catches the word in flight.
module skid_slice
    import skid_pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             ready_q;
    logic             acc, drn;
    logic             load_main_in, load_main_skid, load_skid;

    assign acc = in_valid && ready_q;
    assign drn = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                case ({acc, drn})
                    2'b10: begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end
                    2'b01: state_nxt = EMPTY;
                    // Replace main on the same edge it drains: no bubble.
                    2'b11: load_main_in = 1'b1;
                    default: ;
                endcase
            end
            FULL: begin
                if (drn) begin
                    state_nxt      = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Ready is a flop fed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_data;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/skid_pipeline.sv
// Elastic pipeline of STAGES skid slices with valid/ready flow control.
// Occupancy is tracked by its own up/down counter at the boundary transfers.
module skid_pipeline
    import skid_pipeline_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(STAGES)-1:0]   occupancy
);

    localparam int OW = occ_width(STAGES);

    logic [STAGES:0]            v, r;
    logic [STAGES:0][WIDTH-1:0] d;
    logic                       in_xfer, out_xfer;

    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign r[STAGES] = out_ready;
    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        skid_slice #(.WIDTH(WIDTH)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v[k]),
            .in_ready  (r[k]),
            .in_data   (d[k]),
            .out_valid (v[k+1]),
            .out_ready (r[k+1]),
            .out_data  (d[k+1])
        );
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occupancy <= '0;
        else begin
            case ({in_xfer, out_xfer})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skid_pipeline.sv
// Directed and random-backpressure checks of skid_pipeline at STAGES=2 and STAGES=1.
// Inputs change #1 after each rising edge; outputs are sampled there too.
module tb_skid_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_occupancy;

    int n_assert = 0;
    int n_fail   = 0;

    skid_pipeline #(.WIDTH(8), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    skid_pipeline #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] dat, exp_b;
        int         cnt;
        logic       acc, stalled;

        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'h00;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        tick();
        rst = 1'b0;

        // Reset mid-stream
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        chk("mid_occ_before", 32'(occupancy), 32'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_occupancy", 32'(occupancy), 32'd0);
        chk("mid_in_ready",  32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_stale", 32'({out_valid, occupancy}), 32'd0);
        end

        // Streaming 0x01..0x10, 2-cycle latency
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i + 1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 0)
                chk("stream_latency", 32'(out_valid), 32'd0);
            else
                chk("stream_out", 32'({out_valid, out_data}), 32'({1'b1, 8'(i)}));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_last", 32'({out_valid, out_data}), 32'h110);
        tick();
        chk("stream_empty", 32'({out_valid, occupancy}), 32'd0);

        // Fill to capacity with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1;
        dat = 8'hA0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = dat;
            acc = in_ready;
            tick();
            if (acc) begin
                cnt++;
                dat = dat + 8'd1;
            end
        end
        chk("fill_count",     32'(cnt), 32'd4);
        chk("fill_in_ready",  32'(in_ready), 32'd0);
        chk("fill_occupancy", 32'(occupancy), 32'd4);
        chk("fill_head",      32'({out_valid, out_data}), 32'h1A0);

        // Drain
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_word", 32'({out_valid, out_data}), 32'({1'b1, 8'(8'hA0 + k)}));
            tick();
        end
        chk("drain_empty", 32'({out_valid, occupancy}), 32'd0);

        // Random valid/backpressure with scoreboard
        stalled = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!stalled) begin
                in_valid = 1'($urandom_range(1));
                in_data  = 8'($urandom);
            end
            out_ready = 1'($urandom_range(1));
            stalled = in_valid && !in_ready;
            if (out_valid && out_ready) begin
                if (q.size() == 0)
                    chk("rand_underflow", 32'(out_data), 32'hFFFF_FFFF);
                else
                    chk("rand_order", 32'(out_data), 32'(q.pop_front()));
            end
            if (in_valid && in_ready)
                q.push_back(in_data);
            tick();
            chk("rand_occupancy", 32'(occupancy), 32'(q.size()));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            if (out_valid)
                chk("rand_tail", 32'(out_data), 32'(q.pop_front()));
            tick();
        end
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_final", 32'({out_valid, occupancy}), 32'd0);

        // STAGES=1: accept and drain together every cycle
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_b = 8'(8'h50 + i);
            b_in_data = exp_b;
            chk("s1_in_ready", 32'(b_in_ready), 32'd1);
            tick();
            chk("s1_out", 32'({b_out_valid, b_out_data}), 32'({1'b1, exp_b}));
            chk("s1_occ", 32'(b_occupancy), 32'd1);
        end
        b_in_valid = 1'b0;
        tick();
        chk("s1_empty", 32'({b_out_valid, b_occupancy}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
